// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg : shared types and stage-control encodings for hazard_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

   localparam int c_REG_W_DEF     = 4;
   localparam int c_CNT_W_DEF     = 16;
   localparam int c_DRAIN_CYC_DEF = 3;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DMEM_WAIT = 2'd1,
      ST_DRAIN     = 2'd2,
      ST_HALTED    = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_write;
      logic memwb_flush;
      logic halted;
   } ctrl_t;

   localparam ctrl_t c_CTRL_RUN      = '{pc_write:1'b1, ifid_write:1'b1, ifid_flush:1'b0,
                                         idex_flush:1'b0, exmem_write:1'b1, memwb_flush:1'b0,
                                         halted:1'b0};
   localparam ctrl_t c_CTRL_FREEZE   = '{pc_write:1'b0, ifid_write:1'b0, ifid_flush:1'b0,
                                         idex_flush:1'b0, exmem_write:1'b0, memwb_flush:1'b1,
                                         halted:1'b0};
   localparam ctrl_t c_CTRL_BUBBLE   = '{pc_write:1'b0, ifid_write:1'b0, ifid_flush:1'b0,
                                         idex_flush:1'b1, exmem_write:1'b1, memwb_flush:1'b0,
                                         halted:1'b0};
   localparam ctrl_t c_CTRL_REDIRECT = '{pc_write:1'b1, ifid_write:1'b1, ifid_flush:1'b1,
                                         idex_flush:1'b0, exmem_write:1'b1, memwb_flush:1'b0,
                                         halted:1'b0};
   // HLT entry and I-fetch stall share one pattern: IF/ID takes a NOP, PC holds.
   localparam ctrl_t c_CTRL_IFSTALL  = '{pc_write:1'b0, ifid_write:1'b1, ifid_flush:1'b1,
                                         idex_flush:1'b0, exmem_write:1'b1, memwb_flush:1'b0,
                                         halted:1'b0};
   localparam ctrl_t c_CTRL_DRAIN    = '{pc_write:1'b0, ifid_write:1'b0, ifid_flush:1'b1,
                                         idex_flush:1'b0, exmem_write:1'b1, memwb_flush:1'b0,
                                         halted:1'b0};
   localparam ctrl_t c_CTRL_HALTED   = '{pc_write:1'b0, ifid_write:1'b0, ifid_flush:1'b0,
                                         idex_flush:1'b0, exmem_write:1'b0, memwb_flush:1'b0,
                                         halted:1'b1};
   localparam ctrl_t c_CTRL_RESET    = '{pc_write:1'b0, ifid_write:1'b0, ifid_flush:1'b1,
                                         idex_flush:1'b1, exmem_write:1'b0, memwb_flush:1'b0,
                                         halted:1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline-status inputs and stage-control outputs of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] IFID_Rs;
   logic [REG_W-1:0] IFID_Rt;
   logic             IFID_UsesRs;
   logic             IFID_UsesRt;
   logic             IFID_IsBranch;
   logic             IFID_IsBR;
   logic             IFID_Halt;
   logic             ID_BranchTaken;
   logic             IDEX_MemRead;
   logic             IDEX_RegWrite;
   logic             IDEX_WritesFlg;
   logic [REG_W-1:0] IDEX_Rd;
   logic             EXMem_MemRead;
   logic [REG_W-1:0] EXMem_Rd;
   logic             IMem_Stall;
   logic             DMem_Stall;

   logic             PC_Write;
   logic             IFID_Write;
   logic             IFID_Flush;
   logic             IDEX_Flush;
   logic             EXMem_Write;
   logic             MemWB_Flush;
   logic             Halted;
   logic [CNT_W-1:0] StallCount;

   modport master (
      output IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt, IFID_IsBranch, IFID_IsBR,
             IFID_Halt, ID_BranchTaken, IDEX_MemRead, IDEX_RegWrite, IDEX_WritesFlg,
             IDEX_Rd, EXMem_MemRead, EXMem_Rd, IMem_Stall, DMem_Stall,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMem_Write, MemWB_Flush,
             Halted, StallCount
   );

   modport slave (
      input  IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt, IFID_IsBranch, IFID_IsBR,
             IFID_Halt, ID_BranchTaken, IDEX_MemRead, IDEX_RegWrite, IDEX_WritesFlg,
             IDEX_Rd, EXMem_MemRead, EXMem_Rd, IMem_Stall, DMem_Stall,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMem_Write, MemWB_Flush,
             Halted, StallCount
   );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_detect : combinational load-use / branch-flag / BR-register hazard compare
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl_detect #(
   parameter int REG_W = 4
) (
   input  wire logic [REG_W-1:0] ifid_rs_i,
   input  wire logic [REG_W-1:0] ifid_rt_i,
   input  wire logic             ifid_uses_rs_i,
   input  wire logic             ifid_uses_rt_i,
   input  wire logic             ifid_is_branch_i,
   input  wire logic             ifid_is_br_i,
   input  wire logic             idex_mem_read_i,
   input  wire logic             idex_reg_write_i,
   input  wire logic             idex_writes_flg_i,
   input  wire logic [REG_W-1:0] idex_rd_i,
   input  wire logic             exmem_mem_read_i,
   input  wire logic [REG_W-1:0] exmem_rd_i,
   output logic                  lu_o,
   output logic                  bf_o,
   output logic                  br_o
);
   logic w_rs_hit_ex;
   logic w_rt_hit_ex;
   logic w_br_hit_ex;
   logic w_br_hit_mem;

   // Register 0 is hardwired, so it never creates a dependency.
   assign w_rs_hit_ex  = ifid_uses_rs_i & (ifid_rs_i == idex_rd_i);
   assign w_rt_hit_ex  = ifid_uses_rt_i & (ifid_rt_i == idex_rd_i);
   assign lu_o         = idex_mem_read_i & (idex_rd_i != '0) & (w_rs_hit_ex | w_rt_hit_ex);

   assign bf_o         = ifid_is_branch_i & idex_writes_flg_i;

   assign w_br_hit_ex  = idex_reg_write_i & (idex_rd_i == ifid_rs_i);
   assign w_br_hit_mem = exmem_mem_read_i & (exmem_rd_i == ifid_rs_i);
   assign br_o         = ifid_is_br_i & (ifid_rs_i != '0) & (w_br_hit_ex | w_br_hit_mem);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : 5-stage pipeline sequencer (stall, flush, freeze, drain, stall counter)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_W     = c_REG_W_DEF,
   parameter int CNT_W     = c_CNT_W_DEF,
   parameter int DRAIN_CYC = c_DRAIN_CYC_DEF
) (
   input  wire logic        clk,
   input  wire logic        rst,
   hazard_ctrl_if.slave     pipe
);
   localparam int             c_DC_W       = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
   localparam logic [c_DC_W-1:0] c_DRAIN_LOAD = c_DC_W'(DRAIN_CYC);

   state_e             state_q, state_d;
   logic [c_DC_W-1:0]  drain_q, drain_d;
   logic [CNT_W-1:0]   stall_q;
   ctrl_t              w_ctrl;
   logic               w_lu, w_bf, w_br, w_hazard, w_count;

   hazard_ctrl_detect #(
      .REG_W (REG_W)
   ) u_detect (
      .ifid_rs_i         (pipe.IFID_Rs),
      .ifid_rt_i         (pipe.IFID_Rt),
      .ifid_uses_rs_i    (pipe.IFID_UsesRs),
      .ifid_uses_rt_i    (pipe.IFID_UsesRt),
      .ifid_is_branch_i  (pipe.IFID_IsBranch),
      .ifid_is_br_i      (pipe.IFID_IsBR),
      .idex_mem_read_i   (pipe.IDEX_MemRead),
      .idex_reg_write_i  (pipe.IDEX_RegWrite),
      .idex_writes_flg_i (pipe.IDEX_WritesFlg),
      .idex_rd_i         (pipe.IDEX_Rd),
      .exmem_mem_read_i  (pipe.EXMem_MemRead),
      .exmem_rd_i        (pipe.EXMem_Rd),
      .lu_o              (w_lu),
      .bf_o              (w_bf),
      .br_o              (w_br)
   );

   assign w_hazard = w_lu | w_bf | w_br;

   always_comb begin
      w_ctrl  = c_CTRL_RUN;
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         // DMEM_WAIT behaves like RUN once memory releases, so hazards are re-evaluated.
         ST_RUN, ST_DMEM_WAIT: begin
            if (pipe.DMem_Stall) begin
               w_ctrl  = c_CTRL_FREEZE;
               state_d = ST_DMEM_WAIT;
            end else if (w_hazard) begin
               w_ctrl  = c_CTRL_BUBBLE;
               state_d = ST_RUN;
            end else if (pipe.IFID_Halt) begin
               w_ctrl  = c_CTRL_IFSTALL;
               drain_d = c_DRAIN_LOAD;
               state_d = ST_DRAIN;
            end else if (pipe.IFID_IsBranch & pipe.ID_BranchTaken) begin
               w_ctrl  = c_CTRL_REDIRECT;
               state_d = ST_RUN;
            end else if (pipe.IMem_Stall) begin
               w_ctrl  = c_CTRL_IFSTALL;
               state_d = ST_RUN;
            end else begin
               w_ctrl  = c_CTRL_RUN;
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (pipe.DMem_Stall) begin
               w_ctrl = c_CTRL_FREEZE;
            end else begin
               w_ctrl = c_CTRL_DRAIN;
               if (drain_q <= c_DC_W'(1)) begin
                  drain_d = '0;
                  state_d = ST_HALTED;
               end else begin
                  drain_d = drain_q - c_DC_W'(1);
               end
            end
         end
         ST_HALTED: begin
            w_ctrl = c_CTRL_HALTED;
         end
         default: begin
            w_ctrl  = c_CTRL_RESET;
            state_d = ST_RUN;
         end
      endcase
      if (rst) begin
         w_ctrl = c_CTRL_RESET;
      end
   end

   assign w_count = ~w_ctrl.pc_write & (state_q != ST_HALTED) & (stall_q != '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         if (w_count) begin
            stall_q <= stall_q + CNT_W'(1);
         end
      end
   end

   assign pipe.PC_Write    = w_ctrl.pc_write;
   assign pipe.IFID_Write  = w_ctrl.ifid_write;
   assign pipe.IFID_Flush  = w_ctrl.ifid_flush;
   assign pipe.IDEX_Flush  = w_ctrl.idex_flush;
   assign pipe.EXMem_Write = w_ctrl.exmem_write;
   assign pipe.MemWB_Flush = w_ctrl.memwb_flush;
   assign pipe.Halted      = w_ctrl.halted;
   assign pipe.StallCount  = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed stimulus with queued expectations checked by a monitor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
   // Output vector order: PC_Write IFID_Write IFID_Flush IDEX_Flush EXMem_Write MemWB_Flush Halted
   localparam logic [6:0] E_NORM   = 7'b1100100;
   localparam logic [6:0] E_BUB    = 7'b0001100;
   localparam logic [6:0] E_FRZ    = 7'b0000010;
   localparam logic [6:0] E_TAKEN  = 7'b1110100;
   localparam logic [6:0] E_IFST   = 7'b0110100;
   localparam logic [6:0] E_DRAIN  = 7'b0010100;
   localparam logic [6:0] E_HALTED = 7'b0000001;
   localparam logic [6:0] E_RST    = 7'b0011000;
   localparam logic [6:0] M_ALL    = 7'b1111111;
   localparam logic [6:0] M_RST    = 7'b1111101;

   typedef struct {
      logic [6:0] v;
      logic [6:0] m;
      logic [3:0] cnt;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   exp_t  sb[$];
   string sb_name[$];
   int    checks = 0;
   int    errors = 0;

   hazard_ctrl_if #(.REG_W(4), .CNT_W(4)) bus ();

   hazard_ctrl #(.REG_W(4), .CNT_W(4), .DRAIN_CYC(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .pipe (bus)
   );

   always #5 clk = ~clk;

   task automatic clr();
      bus.IFID_Rs = '0;        bus.IFID_Rt = '0;
      bus.IFID_UsesRs = 1'b0;  bus.IFID_UsesRt = 1'b0;
      bus.IFID_IsBranch = 1'b0; bus.IFID_IsBR = 1'b0;
      bus.IFID_Halt = 1'b0;    bus.ID_BranchTaken = 1'b0;
      bus.IDEX_MemRead = 1'b0; bus.IDEX_RegWrite = 1'b0;
      bus.IDEX_WritesFlg = 1'b0; bus.IDEX_Rd = '0;
      bus.EXMem_MemRead = 1'b0; bus.EXMem_Rd = '0;
      bus.IMem_Stall = 1'b0;   bus.DMem_Stall = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic expect_out(input logic [6:0] v, input logic [6:0] m, input int cnt,
                             input string name);
      exp_t e;
      e.v = v; e.m = m; e.cnt = 4'(cnt);
      sb.push_back(e);
      sb_name.push_back(name);
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1;
      clr();
      rst = 1'b1;
      expect_out(E_RST, M_RST, 0, name);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare whatever expectation is pending at each falling edge.
   initial begin
      exp_t       e;
      string      n;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n = sb_name.pop_front();
            act = {bus.PC_Write, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Flush,
                   bus.EXMem_Write, bus.MemWB_Flush, bus.Halted};
            checks++;
            if ((act & e.m) !== (e.v & e.m)) begin
               errors++;
               $display("FAIL %s ctrl: got %b expected %b (mask %b)", n, act, e.v, e.m);
            end
            checks++;
            if (bus.StallCount !== e.cnt) begin
               errors++;
               $display("FAIL %s StallCount: got %0d expected %0d", n, bus.StallCount, e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      // Load-use on Rs
      do_reset("reset0");
      cyc(); bus.IDEX_MemRead = 1'b1; bus.IDEX_Rd = 4'd3; bus.IFID_Rs = 4'd3;
             bus.IFID_UsesRs = 1'b1;  expect_out(E_BUB, M_ALL, 0, "lu_rs");
      cyc(); expect_out(E_NORM, M_ALL, 1, "lu_after");

      // Zero register never matches; Rt only counts when used
      do_reset("reset1");
      cyc(); bus.IDEX_MemRead = 1'b1; bus.IFID_UsesRs = 1'b1;
             expect_out(E_NORM, M_ALL, 0, "lu_zero");
      cyc(); bus.IDEX_MemRead = 1'b1; bus.IDEX_Rd = 4'd7; bus.IFID_Rt = 4'd7;
             expect_out(E_NORM, M_ALL, 0, "lu_rt_unused");
      cyc(); bus.IDEX_MemRead = 1'b1; bus.IDEX_Rd = 4'd7; bus.IFID_Rt = 4'd7;
             bus.IFID_UsesRt = 1'b1;  expect_out(E_BUB, M_ALL, 0, "lu_rt");
      cyc(); expect_out(E_NORM, M_ALL, 1, "lu_rt_after");

      // DMem freeze over a load-use
      do_reset("reset2");
      for (int i = 0; i < 4; i++) begin
         cyc(); bus.IDEX_MemRead = 1'b1; bus.IDEX_Rd = 4'd3; bus.IFID_Rs = 4'd3;
                bus.IFID_UsesRs = 1'b1; bus.DMem_Stall = 1'b1;
                expect_out(E_FRZ, M_ALL, i, "dmem_frz");
      end
      cyc(); bus.IDEX_MemRead = 1'b1; bus.IDEX_Rd = 4'd3; bus.IFID_Rs = 4'd3;
             bus.IFID_UsesRs = 1'b1;  expect_out(E_BUB, M_ALL, 4, "dmem_lu");
      cyc(); expect_out(E_NORM, M_ALL, 5, "dmem_after");

      // Taken branch, then branch behind a flag writer
      do_reset("reset3");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.ID_BranchTaken = 1'b1;
             expect_out(E_TAKEN, M_ALL, 0, "b_taken");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.ID_BranchTaken = 1'b1; bus.IDEX_WritesFlg = 1'b1;
             expect_out(E_BUB, M_ALL, 0, "b_flag");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.ID_BranchTaken = 1'b1;
             expect_out(E_TAKEN, M_ALL, 1, "b_flag_go");
      cyc(); expect_out(E_NORM, M_ALL, 1, "b_after");

      // BR register dependency, zero-Rs exclusion, IMem interaction
      do_reset("reset4");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.IFID_IsBR = 1'b1; bus.ID_BranchTaken = 1'b1;
             bus.IFID_Rs = 4'd5; bus.IDEX_RegWrite = 1'b1; bus.IDEX_Rd = 4'd5;
             expect_out(E_BUB, M_ALL, 0, "br_ex");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.IFID_IsBR = 1'b1; bus.ID_BranchTaken = 1'b1;
             bus.IFID_Rs = 4'd5; bus.EXMem_MemRead = 1'b1; bus.EXMem_Rd = 4'd5;
             expect_out(E_BUB, M_ALL, 1, "br_mem");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.IFID_IsBR = 1'b1; bus.ID_BranchTaken = 1'b1;
             bus.IFID_Rs = 4'd5; bus.IDEX_RegWrite = 1'b1; bus.IDEX_Rd = 4'd6;
             expect_out(E_TAKEN, M_ALL, 2, "br_nohit");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.IFID_IsBR = 1'b1; bus.ID_BranchTaken = 1'b1;
             bus.IDEX_RegWrite = 1'b1;
             expect_out(E_TAKEN, M_ALL, 2, "br_zero");
      cyc(); bus.IFID_IsBranch = 1'b1; bus.ID_BranchTaken = 1'b1; bus.IMem_Stall = 1'b1;
             expect_out(E_TAKEN, M_ALL, 2, "b_imem");
      cyc(); bus.IMem_Stall = 1'b1; expect_out(E_IFST, M_ALL, 2, "imem");
      cyc(); expect_out(E_NORM, M_ALL, 3, "imem_after");

      // HLT drain and hold
      do_reset("reset5");
      cyc(); bus.IFID_Halt = 1'b1; expect_out(E_IFST, M_ALL, 0, "hlt");
      cyc(); expect_out(E_DRAIN, M_ALL, 1, "drain1");
      cyc(); expect_out(E_DRAIN, M_ALL, 2, "drain2");
      cyc(); expect_out(E_DRAIN, M_ALL, 3, "drain3");
      cyc(); expect_out(E_HALTED, M_ALL, 4, "halted");
      cyc(); bus.IMem_Stall = 1'b1; expect_out(E_HALTED, M_ALL, 4, "halted_hold");

      // DMem freeze inside DRAIN does not consume a drain cycle
      do_reset("reset6");
      cyc(); bus.IFID_Halt = 1'b1; expect_out(E_IFST, M_ALL, 0, "hlt_b");
      cyc(); expect_out(E_DRAIN, M_ALL, 1, "drain_b1");
      cyc(); bus.DMem_Stall = 1'b1; expect_out(E_FRZ, M_ALL, 2, "drain_frz");
      cyc(); expect_out(E_DRAIN, M_ALL, 3, "drain_b2");
      cyc(); expect_out(E_DRAIN, M_ALL, 4, "drain_b3");
      cyc(); expect_out(E_HALTED, M_ALL, 5, "halted_b");

      // Reset in the middle of DRAIN
      do_reset("reset7");
      cyc(); bus.IFID_Halt = 1'b1; expect_out(E_IFST, M_ALL, 0, "hlt_c");
      cyc(); expect_out(E_DRAIN, M_ALL, 1, "drain_c1");
      cyc(); expect_out(E_DRAIN, M_ALL, 2, "drain_c2");
      do_reset("rst_mid_drain");
      cyc(); expect_out(E_NORM, M_ALL, 0, "run_after_rst");

      // Saturation of the 4-bit counter over 21 stall cycles
      do_reset("reset8");
      for (int i = 0; i < 21; i++) begin
         cyc(); bus.IMem_Stall = 1'b1;
                expect_out(E_IFST, M_ALL, (i > 15) ? 15 : i, "sat");
      end
      cyc(); expect_out(E_NORM, M_ALL, 15, "sat_final");

      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
